// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bus: upstream op, ALU drive/return, and writeback result.
// master = surrounding environment (decode, ALU, writeback); slave = issue stage.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_bit30;
   logic [63:0] in_rs1_data;
   logic [63:0] in_rs2_data;
   logic [63:0] in_imm;
   logic [63:0] in_pc;
   logic [4:0]  in_rd;

   logic [4:0]  alu_funct;
   logic [63:0] alu_operand_a;
   logic [63:0] alu_operand_b;
   logic [63:0] alu_result;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;

   modport master (
      output in_valid, in_opcode, in_funct3, in_bit30, in_rs1_data, in_rs2_data,
             in_imm, in_pc, in_rd, alu_result, out_ready,
      input  in_ready, alu_funct, alu_operand_a, alu_operand_b,
             out_valid, out_result, out_rd, out_illegal
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_bit30, in_rs1_data, in_rs2_data,
             in_imm, in_pc, in_rd, alu_result, out_ready,
      output in_ready, alu_funct, alu_operand_a, alu_operand_b,
             out_valid, out_result, out_rd, out_illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready issue stage in front of a combinational RV64I ALU.
// Stage 1 registers the decoded function code and operands onto the ALU inputs;
// stage 2 captures the ALU result and holds it for writeback under backpressure.
module alu_issue_stage (
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   alu_issue_if.slave bus
);
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

   // decode results
   logic [63:0] dec_a;
   logic [63:0] dec_b;
   logic [4:0]  dec_funct;
   logic        dec_illegal;
   logic        w_funct3_ok;

   // stage 1 state
   logic        s1_valid_reg;
   logic [4:0]  s1_rd_reg;
   logic        s1_illegal_reg;
   logic [4:0]  alu_funct_reg;
   logic [63:0] operand_a_reg;
   logic [63:0] operand_b_reg;

   // stage 2 state
   logic        out_valid_reg;
   logic [63:0] out_result_reg;
   logic [4:0]  out_rd_reg;
   logic        out_illegal_reg;

   logic advance2;
   logic accept;

   assign advance2    = !out_valid_reg || bus.out_ready;
   assign bus.in_ready = (!s1_valid_reg || advance2) && !reset;
   assign accept      = bus.in_valid && bus.in_ready;

   // Word ops only exist as ADD/SUB, SLL and SRL/SRA.
   assign w_funct3_ok = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                        (bus.in_funct3 == 3'b101);

   // Decode opcode/funct3/bit30 into ALU function code and operand selection.
   always_comb begin
      dec_a       = '0;
      dec_b       = '0;
      dec_funct   = '0;
      dec_illegal = 1'b0;
      case (bus.in_opcode)
         OPC_OP: begin
            dec_a     = bus.in_rs1_data;
            dec_b     = bus.in_rs2_data;
            dec_funct = {1'b0,
                         bus.in_bit30 && ((bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b101)),
                         bus.in_funct3};
         end
         OPC_OP_IMM: begin
            // bit30 of an immediate is data except for the SRAI shift-type bit.
            dec_a     = bus.in_rs1_data;
            dec_b     = bus.in_imm;
            dec_funct = {1'b0, bus.in_bit30 && (bus.in_funct3 == 3'b101), bus.in_funct3};
         end
         OPC_OP_32: begin
            if (w_funct3_ok) begin
               dec_a     = bus.in_rs1_data;
               dec_b     = bus.in_rs2_data;
               dec_funct = {1'b1,
                            bus.in_bit30 && ((bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b101)),
                            bus.in_funct3};
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM_32: begin
            if (w_funct3_ok) begin
               dec_a     = bus.in_rs1_data;
               dec_b     = bus.in_imm;
               dec_funct = {1'b1, bus.in_bit30 && (bus.in_funct3 == 3'b101), bus.in_funct3};
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            dec_b = bus.in_imm;
         end
         OPC_AUIPC: begin
            dec_a = bus.in_pc;
            dec_b = bus.in_imm;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Stage 1: capture decoded op; flush only kills the valid bit, data is left as-is.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_reg   <= 1'b0;
         s1_rd_reg      <= '0;
         s1_illegal_reg <= 1'b0;
         alu_funct_reg  <= '0;
         operand_a_reg  <= '0;
         operand_b_reg  <= '0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
      end else if (accept) begin
         s1_valid_reg   <= 1'b1;
         s1_rd_reg      <= bus.in_rd;
         s1_illegal_reg <= dec_illegal;
         alu_funct_reg  <= dec_funct;
         operand_a_reg  <= dec_a;
         operand_b_reg  <= dec_b;
      end else if (advance2) begin
         s1_valid_reg <= 1'b0;
      end
   end

   // Stage 2: capture the ALU result when the writeback slot is free or draining.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_reg   <= 1'b0;
         out_result_reg  <= '0;
         out_rd_reg      <= '0;
         out_illegal_reg <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (advance2) begin
         out_valid_reg <= s1_valid_reg;
         // Data only matters behind a valid op; leaving it untouched otherwise keeps outputs quiet.
         if (s1_valid_reg) begin
            out_result_reg  <= s1_illegal_reg ? 64'd0 : bus.alu_result;
            out_rd_reg      <= s1_rd_reg;
            out_illegal_reg <= s1_illegal_reg;
         end
      end
   end

   assign bus.alu_funct     = alu_funct_reg;
   assign bus.alu_operand_a = operand_a_reg;
   assign bus.alu_operand_b = operand_b_reg;
   assign bus.out_valid     = out_valid_reg;
   assign bus.out_result    = out_result_reg;
   assign bus.out_rd        = out_rd_reg;
   assign bus.out_illegal   = out_illegal_reg;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural RV64I ALU attached.
module tb_alu_issue_stage;
   logic clock;
   logic reset;
   logic flush;

   int num_checks;
   int num_errors;

   alu_issue_if bus ();

   alu_issue_stage dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural ALU: combinational from the stage's alu_* outputs.
   logic [31:0] w_res;
   always_comb begin
      w_res          = '0;
      bus.alu_result = '0;
      if (bus.alu_funct[4]) begin
         case (bus.alu_funct[2:0])
            3'b000:  w_res = bus.alu_funct[3] ? bus.alu_operand_a[31:0] - bus.alu_operand_b[31:0]
                                              : bus.alu_operand_a[31:0] + bus.alu_operand_b[31:0];
            3'b001:  w_res = bus.alu_operand_a[31:0] << bus.alu_operand_b[4:0];
            3'b101:  w_res = bus.alu_funct[3] ? 32'($signed(bus.alu_operand_a[31:0]) >>> bus.alu_operand_b[4:0])
                                              : bus.alu_operand_a[31:0] >> bus.alu_operand_b[4:0];
            default: w_res = '0;
         endcase
         bus.alu_result = {{32{w_res[31]}}, w_res};
      end else begin
         case (bus.alu_funct[2:0])
            3'b000:  bus.alu_result = bus.alu_funct[3] ? bus.alu_operand_a - bus.alu_operand_b
                                                       : bus.alu_operand_a + bus.alu_operand_b;
            3'b001:  bus.alu_result = bus.alu_operand_a << bus.alu_operand_b[5:0];
            3'b010:  bus.alu_result = {63'd0, $signed(bus.alu_operand_a) < $signed(bus.alu_operand_b)};
            3'b011:  bus.alu_result = {63'd0, bus.alu_operand_a < bus.alu_operand_b};
            3'b100:  bus.alu_result = bus.alu_operand_a ^ bus.alu_operand_b;
            3'b101:  bus.alu_result = bus.alu_funct[3] ? 64'($signed(bus.alu_operand_a) >>> bus.alu_operand_b[5:0])
                                                       : bus.alu_operand_a >> bus.alu_operand_b[5:0];
            3'b110:  bus.alu_result = bus.alu_operand_a | bus.alu_operand_b;
            default: bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
         endcase
      end
   end

   // One line per writeback transaction.
   always @(posedge clock) begin
      if (!reset && bus.out_valid && bus.out_ready)
         $display("wb: rd=%0d result=%h illegal=%b", bus.out_rd, bus.out_result, bus.out_illegal);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic b30,
                           input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                           input logic [63:0] pc, input logic [4:0] rd);
      bus.in_valid    = 1'b1;
      bus.in_opcode   = opc;
      bus.in_funct3   = f3;
      bus.in_bit30    = b30;
      bus.in_rs1_data = rs1;
      bus.in_rs2_data = rs2;
      bus.in_imm      = imm;
      bus.in_pc       = pc;
      bus.in_rd       = rd;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      num_checks    = 0;
      num_errors    = 0;
      reset         = 1'b1;
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      drive_op(7'd0, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0);
      idle();
      tick();
      tick();

      // reset state
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_alu_funct", 64'(bus.alu_funct), 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ADD 5+7
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0, 5'd10);
      tick();
      idle();
      check("add_funct", 64'(bus.alu_funct), 64'h00);
      check("add_op_a", bus.alu_operand_a, 64'd5);
      check("add_op_b", bus.alu_operand_b, 64'd7);
      check("add_not_yet", 64'(bus.out_valid), 64'd0);
      tick();
      check("add_valid", 64'(bus.out_valid), 64'd1);
      check("add_result", bus.out_result, 64'd12);
      check("add_rd", 64'(bus.out_rd), 64'd10);
      check("add_illegal", 64'(bus.out_illegal), 64'd0);
      tick();
      check("add_drained", 64'(bus.out_valid), 64'd0);

      // SUB 3-5 then ADDI with bit30 set (must not subtract)
      drive_op(7'b0110011, 3'b000, 1'b1, 64'd3, 64'd5, 64'd0, 64'd0, 5'd1);
      tick();
      drive_op(7'b0010011, 3'b000, 1'b1, 64'd3, 64'd99, 64'd5, 64'd0, 5'd2);
      check("sub_funct", 64'(bus.alu_funct), 64'h08);
      tick();
      idle();
      check("addi_funct", 64'(bus.alu_funct), 64'h00);
      check("addi_op_b", bus.alu_operand_b, 64'd5);
      check("sub_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_rd", 64'(bus.out_rd), 64'd1);
      tick();
      check("addi_result", bus.out_result, 64'd8);
      check("addi_rd", 64'(bus.out_rd), 64'd2);
      tick();

      // ADDW overflow, then SRAIW
      drive_op(7'b0111011, 3'b000, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd4);
      tick();
      drive_op(7'b0011011, 3'b101, 1'b1, 64'h8000_0000, 64'd0, 64'h404, 64'd0, 5'd5);
      check("addw_funct", 64'(bus.alu_funct), 64'h10);
      tick();
      idle();
      check("sraiw_funct", 64'(bus.alu_funct), 64'h1D);
      check("addw_result", bus.out_result, 64'hFFFF_FFFF_8000_0000);
      tick();
      check("sraiw_result", bus.out_result, 64'hFFFF_FFFF_F800_0000);
      check("sraiw_rd", 64'(bus.out_rd), 64'd5);
      tick();

      // LUI, AUIPC back-to-back under backpressure; third op waits
      bus.out_ready = 1'b0;
      drive_op(7'b0110111, 3'b000, 1'b0, 64'hDEAD, 64'd0, 64'h1234_5000, 64'd0, 5'd6);
      tick();
      drive_op(7'b0010111, 3'b000, 1'b0, 64'hBEEF, 64'd0, 64'h2000, 64'h1000, 5'd7);
      #1;
      check("lui_op_a", bus.alu_operand_a, 64'd0);
      check("bp_in_ready_s2_free", 64'(bus.in_ready), 64'd1);
      tick();
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 5'd8);
      #1;
      check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_lui_result", bus.out_result, 64'h1234_5000);
      check("bp_auipc_op_a", bus.alu_operand_a, 64'h1000);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         check("bp_hold_result", bus.out_result, 64'h1234_5000);
         check("bp_hold_rd", 64'(bus.out_rd), 64'd6);
         check("bp_hold_op_a", bus.alu_operand_a, 64'h1000);
         check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      idle();
      check("auipc_result", bus.out_result, 64'h3000);
      check("auipc_rd", 64'(bus.out_rd), 64'd7);
      check("third_op_a", bus.alu_operand_a, 64'd1);
      tick();
      check("third_result", bus.out_result, 64'd2);
      check("third_rd", 64'(bus.out_rd), 64'd8);
      tick();
      check("bp_no_dup", 64'(bus.out_valid), 64'd0);

      // illegal opcode, illegal OP-32 funct3, then a good ADD
      drive_op(7'b1111111, 3'b000, 1'b0, 64'd9, 64'd9, 64'd9, 64'd9, 5'd20);
      tick();
      drive_op(7'b0111011, 3'b010, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 5'd21);
      check("ill_op_a", bus.alu_operand_a, 64'd0);
      check("ill_funct", 64'(bus.alu_funct), 64'd0);
      tick();
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd10, 64'd20, 64'd0, 64'd0, 5'd3);
      check("ill1_flag", 64'(bus.out_illegal), 64'd1);
      check("ill1_result", bus.out_result, 64'd0);
      tick();
      idle();
      check("ill2_flag", 64'(bus.out_illegal), 64'd1);
      check("ill2_result", bus.out_result, 64'd0);
      check("ill2_rd", 64'(bus.out_rd), 64'd21);
      tick();
      check("post_ill_flag", 64'(bus.out_illegal), 64'd0);
      check("post_ill_result", bus.out_result, 64'd30);
      check("post_ill_rd", 64'(bus.out_rd), 64'd3);
      tick();

      // flush with two ops in flight and a third presented
      bus.out_ready = 1'b0;
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd11);
      tick();
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0, 5'd12);
      tick();
      drive_op(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd6, 64'd0, 64'd0, 5'd13);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_data_kept", bus.out_result, 64'd3);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      check("flush_nothing_1", 64'(bus.out_valid), 64'd0);
      tick();
      check("flush_nothing_2", 64'(bus.out_valid), 64'd0);

      // reset asserted mid-stall
      bus.out_ready = 1'b0;
      drive_op(7'b0110011, 3'b000, 1'b1, 64'd9, 64'd4, 64'd0, 64'd0, 5'd14);
      tick();
      drive_op(7'b0010111, 3'b000, 1'b0, 64'd0, 64'd0, 64'h20, 64'h10, 5'd15);
      tick();
      idle();
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_result", bus.out_result, 64'd5);
      reset = 1'b1;
      #1;
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_out_result", bus.out_result, 64'd0);
      check("rst_mid_out_rd", 64'(bus.out_rd), 64'd0);
      check("rst_mid_out_illegal", 64'(bus.out_illegal), 64'd0);
      check("rst_mid_alu_funct", 64'(bus.alu_funct), 64'd0);
      check("rst_mid_op_a", bus.alu_operand_a, 64'd0);
      check("rst_mid_op_b", bus.alu_operand_b, 64'd0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("rst_mid_aborted", 64'(bus.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end
endmodule
